// File: rtl/gpu_loader.sv
// Host byte-stream loader: parses write/run commands, assembles little-endian
// words and issues single-cycle strobes into the shader system's RAM write port.
module gpu_loader #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic [ADDRESS_WIDTH-1:0] ext_write_address,
  output logic [WORD_WIDTH-1:0]    ext_write_data,
  output logic                     ext_enable_write_inst,
  output logic                     ext_enable_write_data,
  output logic                     run,
  input  logic                     halted,
  output logic                     core_done,
  output logic                     error
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_WRITE} state_t;

  state_t                   r_state, w_next;
  logic                     r_is_inst;
  logic [1:0]               r_idx;
  logic [7:0]               r_lo;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [15:0]              r_count;
  logic [23:0]              r_shift;
  logic                     r_run, r_done, r_error;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [WORD_WIDTH-1:0]    r_wr_data;

  logic w_accept, w_write_cmd, w_cnt_zero, w_last;

  assign in_ready    = (r_state != S_WRITE);
  assign w_accept    = in_valid & in_ready;
  assign w_write_cmd = (in_data == 8'h01) || (in_data == 8'h02);
  assign w_cnt_zero  = ({in_data, r_lo} == 16'd0);
  assign w_last      = (r_count == 16'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && w_write_cmd) w_next = S_HDR;
      S_HDR:     if (w_accept && r_idx == 2'd3) w_next = w_cnt_zero ? S_IDLE : S_PAYLOAD;
      S_PAYLOAD: if (w_accept && r_idx == 2'd3) w_next = S_WRITE;
      S_WRITE:   w_next = w_last ? S_IDLE : S_PAYLOAD;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_is_inst <= 1'b0;
      r_idx     <= '0;
      r_lo      <= '0;
      r_addr    <= '0;
      r_count   <= '0;
      r_shift   <= '0;
      r_run     <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= r_run & halted;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_idx <= '0;
          case (in_data)
            8'h00: r_error <= 1'b0;
            8'h01, 8'h02: begin
              r_is_inst <= (in_data == 8'h01);
              r_run     <= 1'b0;
            end
            8'h03:   r_run   <= 1'b1;
            8'h04:   r_run   <= 1'b0;
            default: r_error <= 1'b1;
          endcase
        end
        // r_lo holds addr_lo, then is reused for cnt_lo
        S_HDR: if (w_accept) begin
          r_idx <= r_idx + 2'd1;
          case (r_idx)
            2'd0:    r_lo    <= in_data;
            2'd1:    r_addr  <= ADDRESS_WIDTH'({in_data, r_lo});
            2'd2:    r_lo    <= in_data;
            default: r_count <= {in_data, r_lo};
          endcase
        end
        S_PAYLOAD: if (w_accept) begin
          r_idx   <= r_idx + 2'd1;
          r_shift <= {in_data, r_shift[23:8]};
          if (r_idx == 2'd3) begin
            r_wr_addr <= r_addr;
            r_wr_data <= WORD_WIDTH'({in_data, r_shift});
          end
        end
        S_WRITE: begin
          r_count <= r_count - 16'd1;
          r_addr  <= r_addr + ADDRESS_WIDTH'(4);
        end
        default: ;
      endcase
    end
  end

  assign ext_write_address     = r_wr_addr;
  assign ext_write_data        = r_wr_data;
  assign ext_enable_write_inst = (r_state == S_WRITE) &  r_is_inst;
  assign ext_enable_write_data = (r_state == S_WRITE) & ~r_is_inst;
  assign run                   = r_run;
  assign core_done             = r_done;
  assign error                 = r_error;

endmodule

// File: tb/tb_gpu_loader.sv
// Scoreboard bench for gpu_loader: expected strobes are queued as packets are
// driven and compared when the loader issues them.
module tb_gpu_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] ext_write_address;
  logic [31:0] ext_write_data;
  logic        ext_enable_write_inst;
  logic        ext_enable_write_data;
  logic        run;
  logic        halted;
  logic        core_done;
  logic        error;

  gpu_loader #(.WORD_WIDTH(32), .ADDRESS_WIDTH(16)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .in_valid              (in_valid),
    .in_data               (in_data),
    .in_ready              (in_ready),
    .ext_write_address     (ext_write_address),
    .ext_write_data        (ext_write_data),
    .ext_enable_write_inst (ext_enable_write_inst),
    .ext_enable_write_data (ext_enable_write_data),
    .run                   (run),
    .halted                (halted),
    .core_done             (core_done),
    .error                 (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        inst;
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tx_words[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          gaps_en  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int unsigned gap;
    gap = gaps_en ? $urandom_range(0, 3) : 0;
    if (gap != 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clock);
    if (!in_ready) check("ready_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic send_write(input logic [7:0] cmd, input logic [15:0] addr, input int unsigned n);
    logic [31:0] w;
    logic [15:0] cnt;
    cnt = n[15:0];
    send_byte(cmd);
    check("run_cleared_by_write", run, 0);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    for (int i = 0; i < int'(n); i++) begin
      w = tx_words[i];
      for (int j = 0; j < 4; j++) begin
        if (j == 3) exp_q.push_back('{cmd == 8'h01, 16'(addr + 16'(4 * i)), w});
        send_byte(w[8*j +: 8]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
    check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  always @(negedge clock) begin
    exp_t e;
    check("in_ready_vs_strobe", in_ready, !(ext_enable_write_inst | ext_enable_write_data));
    if (ext_enable_write_inst | ext_enable_write_data) begin
      check("strobe_one_hot", ext_enable_write_inst & ext_enable_write_data, 0);
      check("run_at_strobe", run, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_inst", ext_enable_write_inst, e.inst);
        check("strobe_data_sel", ext_enable_write_data, !e.inst);
        check("strobe_addr", ext_write_address, e.addr);
        check("strobe_data", ext_write_data, e.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    halted   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_run", run, 0);
    check("rst_inst", ext_enable_write_inst, 0);
    check("rst_data_we", ext_enable_write_data, 0);
    check("rst_core_done", core_done, 0);
    check("rst_error", error, 0);
    check("rst_addr", ext_write_address, 0);
    check("rst_wdata", ext_write_data, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic instruction write
    tx_words = '{32'hDEADBEEF, 32'h12345678};
    send_write(8'h01, 16'h0010, 2);
    wait_drain();
    check("addr_hold", ext_write_address, 16'h0014);
    check("data_hold", ext_write_data, 32'h12345678);

    // Data write wrapping at top of address space
    tx_words = '{32'h0BADF00D, 32'h600DCAFE};
    send_write(8'h02, 16'hFFFC, 2);
    wait_drain();

    // RUN, core_done lag, then write clears run before strobe
    halted = 1'b1;
    send_byte(8'h03);
    in_valid = 1'b0;
    check("run_set", run, 1);
    check("core_done_lag", core_done, 0);
    @(negedge clock);
    check("core_done_set", core_done, 1);
    tx_words = '{32'hA5A50001};
    send_write(8'h02, 16'h0000, 1);
    wait_drain();
    check("core_done_clear", core_done, 0);
    halted = 1'b0;

    // Zero-count write, then RUN is decoded as a command
    send_write(8'h01, 16'h0040, 0);
    send_byte(8'h03);
    in_valid = 1'b0;
    check("run_after_cnt0", run, 1);
    send_byte(8'h04);
    in_valid = 1'b0;
    check("run_stop", run, 0);

    // Sticky error
    send_byte(8'h7F);
    in_valid = 1'b0;
    check("error_set", error, 1);
    tx_words = '{32'h01020304};
    send_write(8'h01, 16'h0100, 1);
    wait_drain();
    check("error_sticky", error, 1);
    send_byte(8'h00);
    in_valid = 1'b0;
    check("error_nop_clear", error, 0);

    // Reset mid-payload
    send_byte(8'h7F);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("mid_rst_run", run, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_addr", ext_write_address, 0);
    check("mid_rst_wdata", ext_write_data, 0);
    check("mid_rst_strobes", {ext_enable_write_inst, ext_enable_write_data}, 0);
    check("mid_rst_core_done", core_done, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tx_words = '{32'hCAFEF00D};
    send_write(8'h02, 16'h0020, 1);
    wait_drain();

    // Same traffic with random valid gaps
    gaps_en  = 1'b1;
    tx_words = '{32'hDEADBEEF, 32'h12345678};
    send_write(8'h01, 16'h0010, 2);
    tx_words = '{32'h0BADF00D, 32'h600DCAFE};
    send_write(8'h02, 16'hFFFC, 2);
    tx_words = '{32'h11111111, 32'h89ABCDEF, 32'h76543210};
    send_write(8'h01, 16'h0203, 3);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
